// File: rtl/acc_core_param_if.sv
// Memory handshake bundle for acc_core_param: address, read/write strobes and the wait-state ready.
// The DATA bus is a plain inout on the core so the tristate net resolves at a module boundary.
interface acc_core_param_if #(
  parameter int DATA_W = 8
) ();
  localparam int ADDR_W = 2 * DATA_W - 3;

  logic [ADDR_W-1:0] ADDRESS;
  logic              MEM_RD;
  logic              MEM_WR;
  logic              MEM_READY;

  modport master (output ADDRESS, output MEM_RD, output MEM_WR, input MEM_READY);
  modport slave  (input ADDRESS, input MEM_RD, input MEM_WR, output MEM_READY);
endinterface

// File: rtl/acc_core_param.sv
// Single-clock accumulator RISC core: 2-word fetch, 8 ops, RD/WR strobes held until MEM_READY.
// Optional macro CORE_STEP_EN adds a STEP input that must be seen high before each post-retire fetch.
module acc_core_param #(
  parameter int                  DATA_W   = 8,
  parameter logic [2*DATA_W-4:0] RESET_PC = '0
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
`ifdef CORE_STEP_EN
  input  logic              STEP,
`endif
  acc_core_param_if.master  bus,
  inout  wire  [DATA_W-1:0] DATA,
  output logic              HALT,
  output logic              INSTR_DONE,
  output logic [DATA_W-1:0] ACC_OUT
);
  localparam int ADDR_W = 2 * DATA_W - 3;

  typedef enum logic [2:0] {
    S_IF_HI = 3'd0,
    S_IF_LO = 3'd1,
    S_DEC   = 3'd2,
    S_MRD   = 3'd3,
    S_MWR   = 3'd4,
    S_HALT  = 3'd5
`ifdef CORE_STEP_EN
    , S_STEP_WAIT = 3'd6
`endif
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_t;

  state_t            r_state;
  state_t            w_next_state;
  state_t            w_retire_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_ir_hi;
  logic [DATA_W-1:0] r_ir_lo;
  opcode_t           w_opcode;
  logic [ADDR_W-1:0] w_operand;

  assign w_opcode  = opcode_t'(r_ir_hi[DATA_W-1:DATA_W-3]);
  assign w_operand = {r_ir_hi[DATA_W-4:0], r_ir_lo};

`ifdef CORE_STEP_EN
  assign w_retire_state = S_STEP_WAIT;
`else
  assign w_retire_state = S_IF_HI;
`endif

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_state <= S_IF_HI;
      r_pc    <= RESET_PC;
      r_acc   <= '0;
      r_ir_hi <= '0;
      r_ir_lo <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        S_IF_HI: if (bus.MEM_READY) begin
          r_ir_hi <= DATA;
          r_pc    <= r_pc + ADDR_W'(1);
        end
        S_IF_LO: if (bus.MEM_READY) begin
          r_ir_lo <= DATA;
          r_pc    <= r_pc + ADDR_W'(1);
        end
        S_DEC: begin
          // PC already points past this instruction, so +2 skips exactly one 2-word instruction.
          if (w_opcode == OP_SKZ && r_acc == '0) r_pc <= r_pc + ADDR_W'(2);
          else if (w_opcode == OP_JMP)           r_pc <= w_operand;
        end
        S_MRD: if (bus.MEM_READY) begin
          unique case (w_opcode)
            OP_ADD:  r_acc <= r_acc + DATA;
            OP_AND:  r_acc <= r_acc & DATA;
            OP_XOR:  r_acc <= r_acc ^ DATA;
            default: r_acc <= DATA;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaulting every comb output first keeps unlisted paths from inferring latches.
    w_next_state = r_state;
    unique case (r_state)
      S_IF_HI: if (bus.MEM_READY) w_next_state = S_IF_LO;
      S_IF_LO: if (bus.MEM_READY) w_next_state = S_DEC;
      S_DEC: begin
        unique case (w_opcode)
          OP_HLT:         w_next_state = S_HALT;
          OP_SKZ, OP_JMP: w_next_state = w_retire_state;
          OP_STO:         w_next_state = S_MWR;
          default:        w_next_state = S_MRD;
        endcase
      end
      S_MRD, S_MWR: if (bus.MEM_READY) w_next_state = w_retire_state;
      S_HALT:  w_next_state = S_HALT;
`ifdef CORE_STEP_EN
      S_STEP_WAIT: if (STEP) w_next_state = S_IF_HI;
`endif
      default: w_next_state = S_IF_HI;
    endcase
  end

  always_comb begin
    bus.MEM_RD  = 1'b0;
    bus.MEM_WR  = 1'b0;
    bus.ADDRESS = r_pc;
    HALT        = 1'b0;
    INSTR_DONE  = 1'b0;
    if (!SYS_RST) begin
      unique case (r_state)
        S_IF_HI, S_IF_LO: bus.MEM_RD = 1'b1;
        S_DEC: INSTR_DONE = (w_opcode == OP_HLT) || (w_opcode == OP_SKZ) || (w_opcode == OP_JMP);
        S_MRD: begin
          bus.MEM_RD  = 1'b1;
          bus.ADDRESS = w_operand;
          INSTR_DONE  = bus.MEM_READY;
        end
        S_MWR: begin
          bus.MEM_WR  = 1'b1;
          bus.ADDRESS = w_operand;
          INSTR_DONE  = bus.MEM_READY;
        end
        S_HALT:  HALT = 1'b1;
        default: ;
      endcase
    end
  end

  assign DATA    = bus.MEM_WR ? r_acc : 'z;
  assign ACC_OUT = r_acc;
endmodule

// File: tb/tb_acc_core_param.sv
// Self-checking bench for acc_core_param: table of ALU programs plus hand-written sequences,
// a write scoreboard fed at program load and drained by the memory model, and a DATA_W=12 instance.
module tb_acc_core_param;
  localparam int DW = 8;
  localparam int AW = 2 * DW - 3;
`ifdef CORE_STEP_EN
  localparam int STEP_EXTRA = 1;
`else
  localparam int STEP_EXTRA = 0;
`endif

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         stall;
  } vec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst2  = 1'b1;
  logic ready = 1'b1;
`ifdef CORE_STEP_EN
  logic step  = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int stall_len = 0;
  int stall_cnt = 0;
  int wr_count  = 0;
  int done_cnt  = 0;
  int unsigned rd_log [$];
  wr_t exp_wr [$];
  logic [AW-1:0] cap_addr;
  logic          cap_rd, cap_wr;
  logic [DW-1:0] cap_data;

  logic [7:0]  mem  [0:(1<<AW)-1];
  logic [11:0] mem2 [0:63];

  acc_core_param_if #(.DATA_W(DW)) bus ();
  wire  [DW-1:0] data;
  logic          halt, done;
  logic [DW-1:0] acc;

  acc_core_param_if #(.DATA_W(12)) bus2 ();
  wire  [11:0] data2;
  logic        halt2, done2;
  logic [11:0] acc2;

  assign bus.MEM_READY  = ready;
  assign data           = bus.MEM_RD ? mem[bus.ADDRESS] : 'z;
  assign bus2.MEM_READY = 1'b1;
  assign data2          = bus2.MEM_RD ? mem2[bus2.ADDRESS[5:0]] : 'z;

  acc_core_param #(.DATA_W(DW), .RESET_PC(13'h0)) dut (
    .SYS_CLK    (clk),
    .SYS_RST    (rst),
`ifdef CORE_STEP_EN
    .STEP       (step),
`endif
    .bus        (bus),
    .DATA       (data),
    .HALT       (halt),
    .INSTR_DONE (done),
    .ACC_OUT    (acc)
  );

  acc_core_param #(.DATA_W(12), .RESET_PC(21'h0)) dut2 (
    .SYS_CLK    (clk),
    .SYS_RST    (rst2),
`ifdef CORE_STEP_EN
    .STEP       (step),
`endif
    .bus        (bus2),
    .DATA       (data2),
    .HALT       (halt2),
    .INSTR_DONE (done2),
    .ACC_OUT    (acc2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: stalls each transfer by stall_len cycles, checks bus stability, logs reads, scores writes.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      check("rd_wr_exclusive", 32'(bus.MEM_RD & bus.MEM_WR), 32'd0);
      if (rst) begin
        stall_cnt = 0;
        ready     = 1'b1;
      end else if (bus.MEM_RD || bus.MEM_WR) begin
        if (stall_cnt == 0) begin
          cap_addr = bus.ADDRESS;
          cap_rd   = bus.MEM_RD;
          cap_wr   = bus.MEM_WR;
          cap_data = data;
        end else begin
          check("hold_addr", 32'(bus.ADDRESS), 32'(cap_addr));
          check("hold_strobes", 32'({bus.MEM_RD, bus.MEM_WR}), 32'({cap_rd, cap_wr}));
          if (cap_wr) check("hold_data", 32'(data), 32'(cap_data));
        end
        if (stall_cnt < stall_len) begin
          ready = 1'b0;
          stall_cnt++;
        end else begin
          ready     = 1'b1;
          stall_cnt = 0;
          if (bus.MEM_RD) begin
            rd_log.push_back(32'(bus.ADDRESS));
          end else begin
            wr_count++;
            mem[bus.ADDRESS] = data;
            if (exp_wr.size() == 0) begin
              check("unexpected_write_addr", 32'(bus.ADDRESS), 32'hFFFF_FFFF);
            end else begin
              e = exp_wr.pop_front();
              check("write_addr", 32'(bus.ADDRESS), 32'(e.addr));
              check("write_data", 32'(data), 32'(e.data));
            end
          end
        end
      end else begin
        ready = 1'b1;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
  endtask

  task automatic put_ins(input int at, input logic [2:0] op, input logic [AW-1:0] a);
    mem[at]     = {op, a[AW-1:8]};
    mem[at + 1] = a[7:0];
  endtask

  task automatic release_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rd_log.delete();
    wr_count = 0;
    done_cnt = 0;
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input int max_cyc, output int halt_cyc);
    halt_cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (halt) begin
        halt_cyc = i;
        break;
      end
    end
    if (halt_cyc == 0) check("halt_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs [7];
  int   hc;
  int   h2, d2;
  bit   found;

  initial begin
    vecs[0] = '{ADD,  8'hF0, 8'h25, 8'h15, 0};
    vecs[1] = '{ADD,  8'hF0, 8'h25, 8'h15, 3};
    vecs[2] = '{ADD,  8'hFF, 8'h01, 8'h00, 0};
    vecs[3] = '{AND_, 8'hF0, 8'h3C, 8'h30, 0};
    vecs[4] = '{XOR_, 8'hAA, 8'hFF, 8'h55, 3};
    vecs[5] = '{LDA,  8'h12, 8'hC4, 8'hC4, 0};
    vecs[6] = '{ADD,  8'h7F, 8'h01, 8'h80, 0};

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    clear_mem();
    for (int i = 0; i < 64; i++) mem2[i] = 12'h000;

    // Reset state while SYS_RST is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_rd", 32'(bus.MEM_RD), 32'd0);
    check("rst_mem_wr", 32'(bus.MEM_WR), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);

    // HLT at address 0: two fetch reads, HALT from cycle 4, stays halted.
    release_reset();
    @(negedge clk);
    check("first_fetch_rd", 32'(bus.MEM_RD), 32'd1);
    check("first_fetch_addr", 32'(bus.ADDRESS), 32'd0);
    hc = 1;
    if (!halt) begin
      wait_halt(20, hc);
      hc = hc + 1;
    end
    check("hlt_cycle", 32'(hc), 32'd4);
    repeat (5) @(negedge clk);
    check("hlt_stays", 32'(halt), 32'd1);
    check("hlt_read_count", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check("hlt_read0", rd_log[0], 32'd0);
      check("hlt_read1", rd_log[1], 32'd1);
    end
    check("hlt_no_writes", 32'(wr_count), 32'd0);
    check("hlt_done_count", 32'(done_cnt), 32'd1);

    // Table: LDA a; <op> b; STO; HLT.
    foreach (vecs[k]) begin
      clear_mem();
      put_ins(0, LDA, 13'h100);
      put_ins(2, vecs[k].op, 13'h101);
      put_ins(4, STO, 13'h102);
      put_ins(6, HLT, 13'h000);
      mem[13'h100] = vecs[k].a;
      mem[13'h101] = vecs[k].b;
      stall_len = vecs[k].stall;
      exp_wr.push_back('{13'h102, vecs[k].exp});
      release_reset();
      wait_halt(200, hc);
      check("vec_acc", 32'(acc), 32'(vecs[k].exp));
      check("vec_mem", 32'(mem[13'h102]), 32'(vecs[k].exp));
      check("vec_latency", 32'(hc), 32'(16 + 11 * vecs[k].stall + 3 * STEP_EXTRA));
      check("vec_done_count", 32'(done_cnt), 32'd4);
      check("vec_write_count", 32'(wr_count), 32'd1);
      check("vec_sb_empty", 32'(exp_wr.size()), 32'd0);
      exp_wr.delete();
    end
    stall_len = 0;

    // SKZ: taken when ACC==0 (LDA at 4 skipped), not taken when ACC!=0.
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      put_ins(0, LDA, 13'h100);
      put_ins(2, SKZ, 13'h000);
      put_ins(4, LDA, 13'h101);
      put_ins(6, STO, 13'h102);
      put_ins(8, HLT, 13'h000);
      mem[13'h100] = (t == 0) ? 8'h00 : 8'h01;
      mem[13'h101] = 8'h77;
      exp_wr.push_back('{13'h102, (t == 0) ? 8'h00 : 8'h77});
      release_reset();
      wait_halt(200, hc);
      found = 1'b0;
      foreach (rd_log[j]) if (rd_log[j] == 32'd4) found = 1'b1;
      check("skz_fetched_next", 32'(found), (t == 0) ? 32'd0 : 32'd1);
      check("skz_acc", 32'(acc), (t == 0) ? 32'h00 : 32'h77);
      check("skz_sb_empty", 32'(exp_wr.size()), 32'd0);
      exp_wr.delete();
    end

    // JMP to the top address; the low-word fetch wraps to 0.
    clear_mem();
    put_ins(0, JMP, 13'h1FFF);
    mem[13'h1FFF] = 8'h00;
    release_reset();
    wait_halt(50, hc);
    check("jmp_latency", 32'(hc), 32'(7 + STEP_EXTRA));
    check("jmp_read_count", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      check("jmp_fetch_hi", rd_log[2], 32'h1FFF);
      check("jmp_fetch_wrap", rd_log[3], 32'h0000);
    end

    // Reset pulse during a stalled STO: no write, ACC cleared, refetch from address 0.
    clear_mem();
    put_ins(0, LDA, 13'h100);
    put_ins(2, STO, 13'h102);
    put_ins(4, HLT, 13'h000);
    mem[13'h100] = 8'h5A;
    stall_len = 3;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.MEM_WR) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_write", 32'(found), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    @(negedge clk);
    check("abort_rst_wr", 32'(bus.MEM_WR), 32'd0);
    check("abort_rst_rd", 32'(bus.MEM_RD), 32'd0);
    check("abort_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_refetch_rd", 32'(bus.MEM_RD), 32'd1);
    check("abort_refetch_addr", 32'(bus.ADDRESS), 32'd0);
    check("abort_acc", 32'(acc), 32'd0);
    wait_halt(100, hc);
    check("abort_no_write", 32'(wr_count), 32'd0);
    check("abort_mem", 32'(mem[13'h102]), 32'd0);
    check("abort_acc_final", 32'(acc), 32'd0);
    stall_len = 0;

`ifdef CORE_STEP_EN
    // STEP low after a retire idles the core; a STEP pulse starts the next fetch the following cycle.
    clear_mem();
    put_ins(0, LDA, 13'h100);
    put_ins(2, HLT, 13'h000);
    mem[13'h100] = 8'h33;
    step = 1'b0;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check("step_retired", 32'(found), 32'd1);
    found = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.MEM_RD || bus.MEM_WR) found = 1'b1;
    end
    check("step_idle_no_strobes", 32'(found), 32'd0);
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    @(negedge clk);
    check("step_fetch_rd", 32'(bus.MEM_RD), 32'd1);
    check("step_fetch_addr", 32'(bus.ADDRESS), 32'd2);
    step = 1'b1;
    wait_halt(50, hc);
    check("step_acc", 32'(acc), 32'h33);
`endif

    // DATA_W=12 instance: LDA 0xFFF; ADD 0x002; STO; HLT -> 0x001 (carry discarded).
    mem2[0] = {LDA, 9'h0}; mem2[1] = 12'h020;
    mem2[2] = {ADD, 9'h0}; mem2[3] = 12'h021;
    mem2[4] = {STO, 9'h0}; mem2[5] = 12'h022;
    mem2[6] = {HLT, 9'h0}; mem2[7] = 12'h000;
    mem2[32] = 12'hFFF;
    mem2[33] = 12'h002;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    h2 = 0;
    d2 = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done2) d2++;
      if (bus2.MEM_RD || bus2.MEM_WR) check("dw12_addr_range", 32'(bus2.ADDRESS < 21'd64), 32'd1);
      if (bus2.MEM_WR) mem2[bus2.ADDRESS[5:0]] = data2;
      if (halt2) begin
        h2 = i;
        break;
      end
    end
    check("dw12_latency", 32'(h2), 32'(16 + 3 * STEP_EXTRA));
    check("dw12_mem", 32'(mem2[34]), 32'h001);
    check("dw12_acc", 32'(acc2), 32'h001);
    check("dw12_done_count", 32'(d2), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
